// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Definitions shared by the I2S transmitter and the team's I2S receiver.
//   DATA_W_DEF / SLOT_W_DEF : default sample width and BCLK cycles per slot
//   i2s_ch_e                : word-select (lrclk) encoding, 0 = left, 1 = right
//   i2s_pair_t              : one stereo sample pair {left, right}
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int SLOT_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    // Word-select level for each channel as it appears on lrclk.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    // A stereo pair; packed so {left, right} is also the serialisation order.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } i2s_pair_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo
// Small synchronous FIFO holding stereo pairs waiting to be transmitted.
// Read data is presented from the head entry at all times (first-word
// fall-through); full/empty come straight from the registered occupancy count.
// Ports:
//   clk       : system clock, all logic on posedge
//   rst_n     : synchronous active-low reset, empties the FIFO
//   wrData_i  : pair to write
//   push_i    : write request, ignored when full
//   pop_i     : read request, ignored when empty
//   rdData_o  : head entry
//   full_o    : no free entries
//   empty_o   : no stored entries
// ---------------------------------------------------------------------------
module i2s_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign rdData_o = mem_q[rdPtr_q];

    // Requests are qualified against the registered flags, so a pop on a full
    // FIFO never frees room for a push in the same cycle, and a push into an
    // empty FIFO is never visible to a pop in the same cycle. Pointers wrap
    // naturally because the depth is a power of two.
    always_comb begin
        doPush  = push_i & ~full_o;
        doPop   = pop_i & ~empty_o;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// I2S master transmitter, Philips format. Generates BCLK and LRCLK from the
// system clock and serialises 16-bit stereo pairs MSB first, the MSB one BCLK
// after each LRCLK edge. Pairs are buffered in a small FIFO.
// Ports:
//   clk         : system clock, all logic on posedge
//   rst_n       : synchronous active-low reset
//   in_left     : left sample, sent verbatim
//   in_right    : right sample, sent verbatim
//   in_valid    : pair offered
//   in_ready    : FIFO not full; pair transfers when in_valid & in_ready
//   bclk        : bit clock (registered)
//   lrclk       : word select, 0 = left, 1 = right (registered)
//   sd          : serial data, changes on BCLK falling edges (registered)
//   underrun    : 1-clk pulse when a frame starts with the FIFO empty
//   frame_start : 1-clk pulse on the clk where the frame index becomes 0
// ---------------------------------------------------------------------------
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV_HALF = 50,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SLOT_W       = SLOT_W_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sd,
    output logic              underrun,
    output logic              frame_start
);

    localparam int DIV_W   = $clog2(CLK_DIV_HALF);
    localparam int K_W     = $clog2(2 * SLOT_W);
    localparam int FRAME_W = 2 * DATA_W;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               bclk_q, bclk_d;
    logic [K_W-1:0]     k_q, k_d;
    i2s_ch_e            lrclk_q, lrclk_d;
    logic               sd_q, sd_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               underrun_q, underrun_d;
    logic               frameStart_q, frameStart_d;

    logic               divWrap;
    logic               fallEdge;
    logic [K_W-1:0]     kNext;
    logic               frameLoad;
    logic               inDataBit;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [FRAME_W-1:0] fifoData;

    // Pair buffer; the frame logic pops exactly once per frame.
    i2s_tx_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrData_i ({in_left, in_right}),
        .push_i   (in_valid),
        .pop_i    (frameLoad),
        .rdData_o (fifoData),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // Frame timing. Everything visible to the receiver moves only on the clk
    // where BCLK falls, so it is stable by the following rising edge. The
    // frame register is a shift register: left bits leave first, which leaves
    // the right sample at the top ready for the second slot.
    always_comb begin
        divWrap   = (div_q == DIV_W'(CLK_DIV_HALF - 1));
        fallEdge  = divWrap & bclk_q;
        kNext     = (k_q == K_W'(2 * SLOT_W - 1)) ? '0 : k_q + 1'b1;
        frameLoad = fallEdge & (kNext == '0);
        inDataBit = ((kNext >= K_W'(1)) && (kNext <= K_W'(DATA_W))) ||
                    ((kNext >= K_W'(SLOT_W + 1)) && (kNext <= K_W'(SLOT_W + DATA_W)));

        div_d        = divWrap ? '0 : div_q + 1'b1;
        bclk_d       = divWrap ? ~bclk_q : bclk_q;
        k_d          = k_q;
        lrclk_d      = lrclk_q;
        sd_d         = sd_q;
        shift_d      = shift_q;
        underrun_d   = 1'b0;
        frameStart_d = 1'b0;

        if (fallEdge) begin
            k_d     = kNext;
            lrclk_d = (kNext >= K_W'(SLOT_W)) ? CH_RIGHT : CH_LEFT;
            sd_d    = 1'b0;
            if (frameLoad) begin
                shift_d      = fifoEmpty ? '0 : fifoData;
                underrun_d   = fifoEmpty;
                frameStart_d = 1'b1;
            end else if (inDataBit) begin
                sd_d    = shift_q[FRAME_W-1];
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // State and output registers. The frame index starts at its last value so
    // the first falling edge after reset begins a fresh frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            k_q          <= K_W'(2 * SLOT_W - 1);
            lrclk_q      <= CH_RIGHT;
            sd_q         <= 1'b0;
            shift_q      <= '0;
            underrun_q   <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            k_q          <= k_d;
            lrclk_q      <= lrclk_d;
            sd_q         <= sd_d;
            shift_q      <= shift_d;
            underrun_q   <= underrun_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign in_ready    = ~fifoFull;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sd          = sd_q;
    assign underrun    = underrun_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Self-checking bench for i2s_tx. A frame-level model predicts every output
// from the cycle count since reset release and a queue of accepted pairs; a
// capture process rebuilds transmitted frames from the DUT pins so directed
// literal expectations can be checked against whole words.
// ---------------------------------------------------------------------------
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int H     = 50;
    localparam int DW    = 16;
    localparam int SLOT  = 32;
    localparam int DEPTH = 4;
    localparam int FBITS = 2 * SLOT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_left;
    logic [DW-1:0] in_right;
    logic          in_valid;
    logic          in_ready;
    logic          bclk;
    logic          lrclk;
    logic          sd;
    logic          underrun;
    logic          frame_start;

    int assertCount = 0;
    int failCount   = 0;

    // Model state
    int          cyc = 0;
    logic        modelValid = 1'b0;
    logic [31:0] modelQ[$];
    logic [31:0] curPair;
    logic        expBclk, expLr, expSd, expFs, expUr, expReady;

    // Capture state
    logic        prevBclk;
    int          capK = -1;
    logic [63:0] capBits;
    logic [63:0] capLr;
    logic        capUr;
    logic [31:0] framesData[$];
    logic        framesUr[$];
    logic [63:0] framesLr[$];
    int          firstRise = -1, secondRise = -1, firstFall = -1, firstFs = -1;
    int          urPulses = 0;

    i2s_pair_t   pairs[5];
    i2s_pair_t   extra[4];

    i2s_tx #(
        .CLK_DIV_HALF (H),
        .DATA_W       (DW),
        .SLOT_W       (SLOT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sd          (sd),
        .underrun    (underrun),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input i2s_pair_t p, input logic v);
        in_left  = p.left;
        in_right = p.right;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkFrame(input string name, input int idx, input logic [31:0] pair, input logic ur);
        checkOutput({name, "_present"}, 64'(framesData.size() > idx), 64'(1));
        if (framesData.size() > idx) begin
            checkOutput({name, "_data"}, 64'(framesData[idx]), 64'(pair));
            checkOutput({name, "_underrun"}, 64'(framesUr[idx]), 64'(ur));
        end
    endtask

    // Serial bit required at frame index k for a given {left,right} pair.
    function automatic logic expectedSd(input logic [31:0] pair, input int k);
        if (k >= 1 && k <= DW) return pair[2*DW - k];
        if (k >= SLOT + 1 && k <= SLOT + DW) return pair[SLOT + DW - k];
        return 1'b0;
    endfunction

    // Model: n clocks after release, BCLK = floor(n/H) mod 2; every 2H clocks
    // a falling edge advances the frame index; index 0 pops the queue.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc = 0;
                modelQ.delete();
                expBclk = 1'b0; expLr = 1'b1; expSd = 1'b0;
                expFs = 1'b0; expUr = 1'b0; curPair = '0;
                modelValid = 1'b1;
            end else if (modelValid) begin
                int  preSize;
                logic accept;
                preSize = modelQ.size();
                accept  = in_valid && (preSize < DEPTH);
                cyc++;
                expFs   = 1'b0;
                expUr   = 1'b0;
                expBclk = ((cyc / H) % 2) == 1;
                if (cyc % (2 * H) == 0) begin
                    int k;
                    k = ((cyc / (2 * H)) - 1) % FBITS;
                    if (k == 0) begin
                        expFs = 1'b1;
                        if (preSize == 0) begin
                            expUr   = 1'b1;
                            curPair = '0;
                        end else begin
                            curPair = modelQ.pop_front();
                        end
                    end
                    expLr = (k >= SLOT);
                    expSd = expectedSd(curPair, k);
                end
                if (accept) modelQ.push_back({in_left, in_right});
            end
            expReady = (modelQ.size() < DEPTH);
        end
    end

    // Every cycle, every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid) begin
                checkOutput("bclk", 64'(bclk), 64'(expBclk));
                checkOutput("lrclk", 64'(lrclk), 64'(expLr));
                checkOutput("sd", 64'(sd), 64'(expSd));
                checkOutput("frame_start", 64'(frame_start), 64'(expFs));
                checkOutput("underrun", 64'(underrun), 64'(expUr));
                checkOutput("in_ready", 64'(in_ready), 64'(expReady));
            end
        end
    end

    // Rebuild frames from the pins: sd and lrclk sampled after each BCLK fall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevBclk = 1'b0;
                capK     = -1;
            end else begin
                if (underrun === 1'b1) urPulses++;
                if (frame_start === 1'b1 && firstFs < 0) firstFs = cyc;
                if (prevBclk === 1'b0 && bclk === 1'b1) begin
                    if (firstRise < 0) firstRise = cyc;
                    else if (secondRise < 0) secondRise = cyc;
                end
                if (prevBclk === 1'b1 && bclk === 1'b0) begin
                    if (firstFall < 0) firstFall = cyc;
                    if (frame_start === 1'b1) begin
                        capK    = 0;
                        capBits = '0;
                        capLr   = '0;
                        capUr   = underrun;
                    end else if (capK >= 0) begin
                        capK++;
                    end
                    if (capK >= 0) begin
                        capBits[capK] = sd;
                        capLr[capK]   = lrclk;
                        if (capK == FBITS - 1) begin
                            logic [31:0] word;
                            for (int i = 0; i < DW; i++) begin
                                word[31 - i] = capBits[1 + i];
                                word[15 - i] = capBits[SLOT + 1 + i];
                            end
                            framesData.push_back(word);
                            framesUr.push_back(capUr);
                            framesLr.push_back(capLr);
                            capK = -1;
                        end
                    end
                end
                prevBclk = bclk;
            end
        end
    end

    initial begin
        pairs[0] = '{left: 16'hDEAD, right: 16'hBEEF};
        pairs[1] = '{left: 16'h0001, right: 16'h8000};
        pairs[2] = '{left: 16'hFFFF, right: 16'h0000};
        pairs[3] = '{left: 16'h5A5A, right: 16'hC3C3};
        pairs[4] = '{left: 16'h7FFF, right: 16'h8001};
        extra[0] = '{left: 16'h1111, right: 16'h2222};
        extra[1] = '{left: 16'h3333, right: 16'h4444};
        extra[2] = '{left: 16'h5555, right: 16'h6666};
        extra[3] = '{left: 16'h7777, right: 16'h8888};

        rst_n = 1'b0; in_left = '0; in_right = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_bclk", 64'(bclk), 64'(0));
        checkOutput("rst_lrclk", 64'(lrclk), 64'(1));
        checkOutput("rst_sd", 64'(sd), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

        // One pair during frame 0 (frame 0 itself is empty)
        waitCycle(200);
        applyStimulus('{left: 16'hA5C3, right: 16'h1234}, 1'b1);
        applyStimulus('{left: 16'h0000, right: 16'h0000}, 1'b0);

        waitCycle(6450);
        checkOutput("first_rise", 64'(firstRise), 64'(50));
        checkOutput("first_fall", 64'(firstFall), 64'(100));
        checkOutput("first_frame_start", 64'(firstFs), 64'(100));
        checkOutput("bclk_period", 64'(secondRise - firstRise), 64'(100));
        checkFrame("frame0", 0, 32'h0, 1'b1);
        if (framesLr.size() > 0) begin
            checkOutput("lr_k0", 64'(framesLr[0][0]), 64'(0));
            checkOutput("lr_k31", 64'(framesLr[0][31]), 64'(0));
            checkOutput("lr_k32", 64'(framesLr[0][32]), 64'(1));
            checkOutput("lr_k63", 64'(framesLr[0][63]), 64'(1));
        end

        waitCycle(13000);
        checkFrame("frame1", 1, 32'hA5C3_1234, 1'b0);

        // Five back-to-back pairs: four fit, the fifth waits for a pop
        for (int i = 0; i < 4; i++) applyStimulus(pairs[i], 1'b1);
        checkOutput("full_after_4", 64'(in_ready), 64'(0));
        in_left = pairs[4].left; in_right = pairs[4].right; in_valid = 1'b1;
        waitCycle(19250);
        checkOutput("underrun_pulses", 64'(urPulses), 64'(2));
        checkFrame("frame2", 2, 32'h0, 1'b1);
        waitCycle(19299);
        checkOutput("still_full", 64'(in_ready), 64'(0));
        waitCycle(19300);
        checkOutput("pop_frame_start", 64'(frame_start), 64'(1));
        checkOutput("ready_after_pop", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("fifth_accepted", 64'(in_ready), 64'(0));
        in_valid = 1'b0;

        // Refill during frame 7 so three pairs are queued at the reset
        waitCycle(45000);
        for (int i = 0; i < 4; i++) applyStimulus(extra[i], 1'b1);
        applyStimulus(extra[0], 1'b0);
        waitCycle(51250);
        for (int i = 0; i < 5; i++) checkFrame($sformatf("pair%0d", i), 3 + i, pairs[i], 1'b0);

        // Reset at frame index 10
        waitCycle(52300);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_bclk", 64'(bclk), 64'(0));
        checkOutput("mid_rst_lrclk", 64'(lrclk), 64'(1));
        checkOutput("mid_rst_sd", 64'(sd), 64'(0));
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycle(6450);
        checkOutput("frame_total", 64'(framesData.size()), 64'(9));
        checkFrame("post_reset", 8, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
